// File: rtl/mem_pkg.sv
// rtl/mem_pkg.sv - size codes, FSM states and byte-lane helper for mem_hs_ram
package mem_pkg;

    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;

    localparam int LANES_MAX = 128;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WAIT,
        ST_ACCESS,
        ST_DONE,
        ST_HOLD
    } state_t;

    // Lane 0 is the least significant byte; big-endian puts offset 0 in lane nb-1.
    function automatic logic [LANES_MAX-1:0] be_lanes(input logic [1:0] size,
                                                      input int addr_lo,
                                                      input int nb);
        logic [LANES_MAX-1:0] m;
        case (size)
            SZ_BYTE: m = LANES_MAX'(1) << (nb - 1 - addr_lo);
            SZ_HALF: m = LANES_MAX'(3) << (nb - 2 - addr_lo);
            default: m = (LANES_MAX'(1) << nb) - LANES_MAX'(1);
        endcase
        return m;
    endfunction

endpackage

// File: rtl/mem_array_sp.sv
// rtl/mem_array_sp.sv - single-port synchronous byte-enable word array
module mem_array_sp #(
    parameter int DATA_W = 32,
    parameter int WORDS  = 128,
    parameter int AW     = 7
) (
    input  logic                  clk,
    input  logic                  i_we,
    input  logic                  i_re,
    input  logic [DATA_W/8-1:0]   i_be,
    input  logic [AW-1:0]         i_addr,
    input  logic [DATA_W-1:0]     i_wdata,
    output logic [DATA_W-1:0]     o_rdata
);

    logic [DATA_W-1:0] r_mem [WORDS];
    logic [DATA_W-1:0] r_rdata;

    always_ff @(posedge clk) begin
        if (i_we) begin
            for (int b = 0; b < DATA_W/8; b++) begin
                if (i_be[b]) begin
                    r_mem[i_addr][8*b +: 8] <= i_wdata[8*b +: 8];
                end
            end
        end
        if (i_re) begin
            r_rdata <= r_mem[i_addr];
        end
    end

    assign o_rdata = r_rdata;

endmodule

// File: rtl/mem_hs_ram.sv
// rtl/mem_hs_ram.sv - MOV/MOC handshake data memory with wait states; MEM_ALIGN_CHECK_EN enables misalignment error
module mem_hs_ram
    import mem_pkg::*;
#(
    parameter int DATA_W   = 32,
    parameter int DEPTH_B  = 512,
    parameter int ADDR_W   = 9,
    parameter int WAIT_CYC = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              enable,
    input  logic              mov,
    input  logic              rw,
    input  logic [1:0]        size,
    input  logic [ADDR_W-1:0] address,
    input  logic [DATA_W-1:0] data_in,
    output logic [DATA_W-1:0] data_out,
    output logic              moc,
    output logic              busy,
    output logic              err
);

    localparam int NB    = DATA_W / 8;
    localparam int LB    = $clog2(NB);
    localparam int AW    = ADDR_W - LB;
    localparam int WORDS = DEPTH_B / NB;

    state_t              r_state;
    logic [3:0]          r_cnt;
    logic                r_rw;
    logic [1:0]          r_size;
    logic [ADDR_W-1:0]   r_addr;
    logic [DATA_W-1:0]   r_din;
    logic [DATA_W-1:0]   r_data_out;
    logic                r_moc;
    logic                r_busy;
    logic                r_err;

    logic [1:0]          w_size_eff;
    logic [LB-1:0]       w_off_raw;
    logic [LB-1:0]       w_off;
    logic                w_misalign;
    logic [NB-1:0]       w_be;
    logic [DATA_W-1:0]   w_wdata;
    logic [DATA_W-1:0]   w_rdata;
    logic [DATA_W-1:0]   w_rd_sel;
    logic                w_we;
    logic                w_re;

    assign w_size_eff = (r_size == 2'b11) ? SZ_WORD : r_size;
    assign w_off_raw  = r_addr[LB-1:0];

    always_comb begin
        w_off = '0;
        case (w_size_eff)
            SZ_BYTE: w_off = w_off_raw;
            SZ_HALF: w_off = w_off_raw & ~LB'(1);
            default: w_off = '0;
        endcase
    end

`ifdef MEM_ALIGN_CHECK_EN
    assign w_misalign = ((w_size_eff == SZ_HALF) && w_off_raw[0]) ||
                        ((w_size_eff == SZ_WORD) && (w_off_raw != '0));
`else
    assign w_misalign = 1'b0;
`endif

    assign w_be = NB'(be_lanes(w_size_eff, int'(w_off), NB));

    // Right-justified bus data is moved to/from its big-endian lane position.
    always_comb begin
        int sh;
        w_wdata  = r_din;
        w_rd_sel = w_rdata;
        sh       = 0;
        case (w_size_eff)
            SZ_BYTE: begin
                sh       = 8 * (NB - 1 - int'(w_off));
                w_wdata  = DATA_W'(r_din[7:0]) << sh;
                w_rd_sel = (w_rdata >> sh) & DATA_W'(8'hFF);
            end
            SZ_HALF: begin
                sh       = 8 * (NB - 2 - int'(w_off));
                w_wdata  = DATA_W'(r_din[15:0]) << sh;
                w_rd_sel = (w_rdata >> sh) & DATA_W'(16'hFFFF);
            end
            default: begin
                w_wdata  = r_din;
                w_rd_sel = w_rdata;
            end
        endcase
    end

    assign w_we = (r_state == ST_ACCESS) && !r_rw && !w_misalign;
    assign w_re = (r_state == ST_ACCESS) && r_rw;

    mem_array_sp #(
        .DATA_W (DATA_W),
        .WORDS  (WORDS),
        .AW     (AW)
    ) u_array (
        .clk     (clk),
        .i_we    (w_we),
        .i_re    (w_re),
        .i_be    (w_be),
        .i_addr  (r_addr[ADDR_W-1:LB]),
        .i_wdata (w_wdata),
        .o_rdata (w_rdata)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= ST_IDLE;
            r_cnt      <= '0;
            r_rw       <= 1'b0;
            r_size     <= SZ_BYTE;
            r_addr     <= '0;
            r_din      <= '0;
            r_data_out <= '0;
            r_moc      <= 1'b0;
            r_busy     <= 1'b0;
            r_err      <= 1'b0;
        end else begin
            r_moc <= 1'b0;
            if (r_moc) begin
                r_busy <= 1'b0;
            end
            case (r_state)
                ST_IDLE: begin
                    if (enable && mov) begin
                        r_rw   <= rw;
                        r_size <= size;
                        r_addr <= address;
                        r_din  <= data_in;
                        r_busy <= 1'b1;
                        r_err  <= 1'b0;
                        if (WAIT_CYC == 0) begin
                            r_state <= ST_ACCESS;
                        end else begin
                            r_cnt   <= 4'(WAIT_CYC - 1);
                            r_state <= ST_WAIT;
                        end
                    end
                end
                ST_WAIT: begin
                    if (r_cnt == '0) begin
                        r_state <= ST_ACCESS;
                    end else begin
                        r_cnt <= r_cnt - 4'd1;
                    end
                end
                ST_ACCESS: begin
                    r_state <= ST_DONE;
                end
                ST_DONE: begin
                    r_moc <= 1'b1;
                    r_err <= w_misalign;
                    if (r_rw && !w_misalign) begin
                        r_data_out <= w_rd_sel;
                    end
                    r_state <= ST_HOLD;
                end
                ST_HOLD: begin
                    // A level-held request must be released before the next accept.
                    if (!mov) begin
                        r_state <= ST_IDLE;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign data_out = r_data_out;
    assign moc      = r_moc;
    assign busy     = r_busy;
    assign err      = r_err;

endmodule

// File: tb/tb_mem_hs_ram.sv
// tb/tb_mem_hs_ram.sv - directed table-driven bench for mem_hs_ram at WAIT_CYC 0, 1 and 15
module tb_mem_hs_ram;
    import mem_pkg::*;

`ifdef MEM_ALIGN_CHECK_EN
    localparam bit CHK = 1'b1;
`else
    localparam bit CHK = 1'b0;
`endif

    typedef struct {
        int          k;
        logic        rw;
        logic [1:0]  sz;
        logic [8:0]  a;
        logic [31:0] d;
        logic [31:0] dout;
        int          lat;
        logic        err;
    } vec_t;

    logic        clk;
    logic        rst_n;
    logic        enable;
    logic        rw;
    logic [1:0]  size;
    logic [8:0]  address;
    logic [31:0] data_in;
    logic [2:0]  mov_v;
    logic [2:0]  moc_v;
    logic [2:0]  busy_v;
    logic [2:0]  err_v;
    logic [31:0] dout_v [3];

    int checks;
    int errors;

    mem_hs_ram #(.DATA_W(32), .DEPTH_B(512), .ADDR_W(9), .WAIT_CYC(0)) u_dut0 (
        .clk(clk), .rst_n(rst_n), .enable(enable), .mov(mov_v[0]), .rw(rw), .size(size),
        .address(address), .data_in(data_in), .data_out(dout_v[0]), .moc(moc_v[0]),
        .busy(busy_v[0]), .err(err_v[0]));

    mem_hs_ram #(.DATA_W(32), .DEPTH_B(512), .ADDR_W(9), .WAIT_CYC(1)) u_dut1 (
        .clk(clk), .rst_n(rst_n), .enable(enable), .mov(mov_v[1]), .rw(rw), .size(size),
        .address(address), .data_in(data_in), .data_out(dout_v[1]), .moc(moc_v[1]),
        .busy(busy_v[1]), .err(err_v[1]));

    mem_hs_ram #(.DATA_W(32), .DEPTH_B(512), .ADDR_W(9), .WAIT_CYC(15)) u_dut15 (
        .clk(clk), .rst_n(rst_n), .enable(enable), .mov(mov_v[2]), .rw(rw), .size(size),
        .address(address), .data_in(data_in), .data_out(dout_v[2]), .moc(moc_v[2]),
        .busy(busy_v[2]), .err(err_v[2]));

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic op(input int k, input logic rwv, input logic [1:0] sz, input logic [8:0] a,
                      input logic [31:0] d, output int lat, output logic busy_ok,
                      output logic tail_ok);
        enable   = 1'b1;
        rw       = rwv;
        size     = sz;
        address  = a;
        data_in  = d;
        mov_v[k] = 1'b1;
        @(posedge clk); #1;
        mov_v[k] = 1'b0;
        enable   = 1'b0;
        rw       = ~rwv;
        size     = ~sz;
        address  = ~a;
        data_in  = ~d;
        lat      = 0;
        busy_ok  = 1'b1;
        while (moc_v[k] !== 1'b1 && lat < 40) begin
            if (busy_v[k] !== 1'b1) busy_ok = 1'b0;
            @(posedge clk); #1;
            lat++;
        end
        if (busy_v[k] !== 1'b1) busy_ok = 1'b0;
        @(posedge clk); #1;
        tail_ok = (moc_v[k] === 1'b0) && (busy_v[k] === 1'b0);
        enable  = 1'b1;
    endtask

    vec_t vecs [20];

    initial begin
        int   lat;
        int   n;
        logic busy_ok;
        logic tail_ok;

        checks  = 0;
        errors  = 0;
        rst_n   = 1'b0;
        enable  = 1'b0;
        mov_v   = '0;
        rw      = 1'b0;
        size    = SZ_BYTE;
        address = '0;
        data_in = '0;

        vecs[0]  = '{1, 1'b0, SZ_WORD, 9'h010, 32'hDEADBEEF, 32'h00000000, 3, 1'b0};
        vecs[1]  = '{1, 1'b1, SZ_WORD, 9'h010, 32'h0,        32'hDEADBEEF, 3, 1'b0};
        vecs[2]  = '{1, 1'b0, SZ_BYTE, 9'h011, 32'h000000AA, 32'hDEADBEEF, 3, 1'b0};
        vecs[3]  = '{1, 1'b1, SZ_WORD, 9'h010, 32'h0,        32'hDEAABEEF, 3, 1'b0};
        vecs[4]  = '{1, 1'b1, SZ_BYTE, 9'h011, 32'h0,        32'h000000AA, 3, 1'b0};
        vecs[5]  = '{1, 1'b1, SZ_HALF, 9'h012, 32'h0,        32'h0000BEEF, 3, 1'b0};
        vecs[6]  = '{1, 1'b1, SZ_BYTE, 9'h010, 32'h0,        32'h000000DE, 3, 1'b0};
        vecs[7]  = '{1, 1'b0, SZ_WORD, 9'h014, 32'h00000000, 32'h000000DE, 3, 1'b0};
        vecs[8]  = '{1, 1'b0, SZ_HALF, 9'h016, 32'h0000CAFE, 32'h000000DE, 3, 1'b0};
        vecs[9]  = '{1, 1'b1, SZ_WORD, 9'h014, 32'h0,        32'h0000CAFE, 3, 1'b0};
        vecs[10] = '{1, 1'b1, 2'b11,   9'h014, 32'h0,        32'h0000CAFE, 3, 1'b0};
        vecs[11] = '{1, 1'b0, SZ_WORD, 9'h013, 32'h11223344, 32'h0000CAFE, 3, CHK};
        vecs[12] = '{1, 1'b1, SZ_WORD, 9'h010, 32'h0,
                     CHK ? 32'hDEAABEEF : 32'h11223344, 3, 1'b0};
        vecs[13] = '{1, 1'b1, SZ_HALF, 9'h011, 32'h0,
                     CHK ? 32'hDEAABEEF : 32'h00001122, 3, CHK};
        vecs[14] = '{1, 1'b1, SZ_BYTE, 9'h013, 32'h0,
                     CHK ? 32'h000000EF : 32'h00000044, 3, 1'b0};
        vecs[15] = '{0, 1'b0, SZ_WORD, 9'h020, 32'h01020304, 32'h00000000, 2, 1'b0};
        vecs[16] = '{0, 1'b1, SZ_HALF, 9'h022, 32'h0,        32'h00000304, 2, 1'b0};
        vecs[17] = '{0, 1'b1, SZ_BYTE, 9'h021, 32'h0,        32'h00000002, 2, 1'b0};
        vecs[18] = '{2, 1'b0, SZ_WORD, 9'h030, 32'h0BADF00D, 32'h00000000, 17, 1'b0};
        vecs[19] = '{2, 1'b1, SZ_WORD, 9'h030, 32'h0,        32'h0BADF00D, 17, 1'b0};

        repeat (2) @(posedge clk);
        #1;
        for (int k = 0; k < 3; k++) begin
            chk($sformatf("reset_dout%0d", k), dout_v[k], 32'h0);
            chk($sformatf("reset_moc%0d", k),  32'(moc_v[k]), 32'h0);
            chk($sformatf("reset_busy%0d", k), 32'(busy_v[k]), 32'h0);
            chk($sformatf("reset_err%0d", k),  32'(err_v[k]), 32'h0);
        end
        rst_n = 1'b1;
        @(posedge clk); #1;

        for (int i = 0; i < 20; i++) begin
            op(vecs[i].k, vecs[i].rw, vecs[i].sz, vecs[i].a, vecs[i].d, lat, busy_ok, tail_ok);
            chk($sformatf("v%0d_latency", i), 32'(lat), 32'(vecs[i].lat));
            chk($sformatf("v%0d_busy_during", i), 32'(busy_ok), 32'h1);
            chk($sformatf("v%0d_moc_single_busy_clear", i), 32'(tail_ok), 32'h1);
            chk($sformatf("v%0d_data_out", i), dout_v[vecs[i].k], vecs[i].dout);
            chk($sformatf("v%0d_err", i), 32'(err_v[vecs[i].k]), 32'(vecs[i].err));
        end

        // mov is ignored while enable is low
        enable   = 1'b0;
        mov_v[1] = 1'b1;
        repeat (4) @(posedge clk);
        #1;
        chk("disabled_busy", 32'(busy_v[1]), 32'h0);
        chk("disabled_moc", 32'(moc_v[1]), 32'h0);
        mov_v[1] = 1'b0;
        enable   = 1'b1;
        @(posedge clk); #1;

        // level-held mov yields exactly one completion
        rw       = 1'b1;
        size     = SZ_WORD;
        address  = 9'h010;
        mov_v[1] = 1'b1;
        n = 0;
        for (int i = 0; i < 12; i++) begin
            @(posedge clk); #1;
            if (moc_v[1] === 1'b1) n++;
        end
        chk("held_mov_moc_count", 32'(n), 32'd1);
        mov_v[1] = 1'b0;
        @(posedge clk); #1;
        op(1, 1'b1, SZ_BYTE, 9'h010, 32'h0, lat, busy_ok, tail_ok);
        chk("rearm_latency", 32'(lat), 32'd3);
        chk("rearm_data_out", dout_v[1], CHK ? 32'h000000DE : 32'h00000011);

        // reset in WAIT drops the operation
        enable   = 1'b1;
        rw       = 1'b1;
        size     = SZ_BYTE;
        address  = 9'h033;
        mov_v[2] = 1'b1;
        @(posedge clk); #1;
        mov_v[2] = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("wait_busy", 32'(busy_v[2]), 32'h1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("midreset_dout", dout_v[2], 32'h0);
        chk("midreset_busy", 32'(busy_v[2]), 32'h0);
        chk("midreset_moc", 32'(moc_v[2]), 32'h0);
        chk("midreset_err", 32'(err_v[2]), 32'h0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        chk("post_reset_idle_busy", 32'(busy_v[2]), 32'h0);
        op(2, 1'b1, SZ_BYTE, 9'h033, 32'h0, lat, busy_ok, tail_ok);
        chk("post_reset_latency", 32'(lat), 32'd17);
        chk("post_reset_busy", 32'(busy_ok), 32'h1);
        chk("post_reset_tail", 32'(tail_ok), 32'h1);
        chk("post_reset_data_out", dout_v[2], 32'h0000000D);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
